// File: rtl/count_ctrl_pkg.sv
// Shared types and defaults for the count controller slice.
package count_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned PW_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  // Increment an 8-bit counter, sticking at its maximum.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/count_ctrl_if.sv
// Command/status bundle between a controller host and count_ctrl.
interface count_ctrl_if
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned PW    = PW_DEF
);

  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] limit;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic [7:0]       reloads;

  modport master (
    output start, stop, pause, mode, limit, prescale,
    input  count, busy, done, reloads
  );

  modport slave (
    input  start, stop, pause, mode, limit, prescale,
    output count, busy, done, reloads
  );

endinterface

// File: rtl/count_prescaler.sv
// Tick divider: one tick every divide+1 enabled, unfrozen cycles.
module count_prescaler
  import count_ctrl_pkg::*;
#(
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          clear,
  input  logic          freeze,
  input  logic [PW-1:0] divide,
  output logic          tick
);

  logic [PW-1:0] cnt;

  // Tick fires on the cycle the divider reaches its terminal value.
  always_comb begin
    tick = enable && !freeze && !clear && (cnt == divide);
  end

  // Divider register: clear wins, freeze holds, otherwise count and wrap on tick.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !freeze) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// Run controller: start/stop/pause FSM around a prescaled limit counter.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned PW    = PW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  count_ctrl_if.slave   bus
);

  state_t           state;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;
  logic [PW-1:0]    psc_q;

  logic             accept;
  logic             psc_en;
  logic             psc_clear;
  logic             tick;
  logic [WIDTH-1:0] count_inc;

  // Command decode; stop outranks start, and a zero limit never starts a run.
  always_comb begin
    accept    = ((state == IDLE) || (state == DONE)) && !bus.stop &&
                bus.start && (bus.limit != '0);
    psc_en    = (state == RUN) && !bus.stop;
    psc_clear = bus.stop || accept;
    count_inc = bus.count + WIDTH'(1);
  end

  count_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (psc_en),
    .clear  (psc_clear),
    .freeze (bus.pause),
    .divide (psc_q),
    .tick   (tick)
  );

  // FSM with registered count, busy, done and reload outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lim_q       <= '0;
      mode_q      <= 1'b0;
      psc_q       <= '0;
      bus.count   <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.reloads <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.stop) begin
            state     <= IDLE;
            bus.count <= '0;
          end else if (accept) begin
            state       <= RUN;
            lim_q       <= bus.limit;
            mode_q      <= bus.mode;
            psc_q       <= bus.prescale;
            bus.count   <= '0;
            bus.reloads <= '0;
            bus.busy    <= 1'b1;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state     <= IDLE;
            bus.count <= '0;
            bus.busy  <= 1'b0;
          end else if (bus.pause) begin
            state <= HOLD;
          end else if (tick) begin
            // Only auto-reload can sit at the limit while running.
            if (bus.count == lim_q) begin
              bus.count   <= '0;
              bus.reloads <= sat_inc8(bus.reloads);
            end else begin
              bus.count <= count_inc;
              if (count_inc == lim_q) begin
                bus.done <= 1'b1;
                if (!mode_q) begin
                  state    <= DONE;
                  bus.busy <= 1'b0;
                end
              end
            end
          end
        end
        HOLD: begin
          if (bus.stop) begin
            state     <= IDLE;
            bus.count <= '0;
            bus.busy  <= 1'b0;
          end else if (!bus.pause) begin
            state <= RUN;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Directed self-checking bench for count_ctrl.
module tb_count_ctrl;
  import count_ctrl_pkg::*;

  logic clock;
  logic reset;
  int unsigned n_cmp;
  int unsigned n_err;

  count_ctrl_if #(.WIDTH(4), .PW(4)) bus ();

  count_ctrl #(.WIDTH(4), .PW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic ps, input logic md,
                       input logic [3:0] lim, input logic [3:0] pre);
    bus.start    = st;
    bus.stop     = sp;
    bus.pause    = ps;
    bus.mode     = md;
    bus.limit    = lim;
    bus.prescale = pre;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_reloads", 32'(bus.reloads), 0);
    cyc(2);
    reset = 1'b1;

    // One-shot, limit 3, prescale 0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);
    cyc(1);
    bus.start = 1'b0;
    chk("a_busy_c1", 32'(bus.busy), 1);
    chk("a_count_c1", 32'(bus.count), 0);
    cyc(1);
    chk("a_count_c2", 32'(bus.count), 1);
    chk("a_done_c2", 32'(bus.done), 0);
    cyc(1);
    chk("a_count_c3", 32'(bus.count), 2);
    cyc(1);
    chk("a_count_c4", 32'(bus.count), 3);
    chk("a_done_c4", 32'(bus.done), 1);
    chk("a_state_c4", 32'(dut.state), 32'(DONE));
    chk("a_busy_c4", 32'(bus.busy), 0);
    cyc(1);
    chk("a_done_c5", 32'(bus.done), 0);
    chk("a_count_c5", 32'(bus.count), 3);
    cyc(1);
    chk("a_count_c6", 32'(bus.count), 3);

    // One-shot, limit 2, prescale 2, started from DONE
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2);
    cyc(1);
    bus.start = 1'b0;
    chk("b_busy_c1", 32'(bus.busy), 1);
    chk("b_count_c1", 32'(bus.count), 0);
    cyc(2);
    chk("b_count_c3", 32'(bus.count), 0);
    cyc(1);
    chk("b_count_c4", 32'(bus.count), 1);
    chk("b_done_c4", 32'(bus.done), 0);
    cyc(2);
    chk("b_count_c6", 32'(bus.count), 1);
    cyc(1);
    chk("b_count_c7", 32'(bus.count), 2);
    chk("b_done_c7", 32'(bus.done), 1);

    // Stop while in DONE clears count
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("stop_done_count", 32'(bus.count), 0);
    chk("stop_done_state", 32'(dut.state), 32'(IDLE));

    // Zero limit is ignored; stop beats start
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cyc(1);
    chk("zl_busy", 32'(bus.busy), 0);
    chk("zl_state", 32'(dut.state), 32'(IDLE));
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0);
    cyc(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0);
    chk("ss_busy", 32'(bus.busy), 0);
    chk("ss_state", 32'(dut.state), 32'(IDLE));

    // Auto-reload, limit 1, prescale 0, long enough to saturate reloads
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
    cyc(1);
    bus.start = 1'b0;
    chk("r_busy_c1", 32'(bus.busy), 1);
    chk("r_count_c1", 32'(bus.count), 0);
    for (int c = 2; c <= 605; c++) begin
      int unsigned exp_rel;
      int unsigned exp_cnt;
      cyc(1);
      exp_cnt = (c % 2 == 0) ? 1 : 0;
      exp_rel = (c - 1) / 2;
      if (exp_rel > 255) exp_rel = 255;
      chk("r_count", 32'(bus.count), exp_cnt);
      chk("r_done", 32'(bus.done), exp_cnt);
      chk("r_reloads", 32'(bus.reloads), exp_rel);
    end
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("r_stop_count", 32'(bus.count), 0);
    chk("r_stop_busy", 32'(bus.busy), 0);
    chk("r_stop_done", 32'(bus.done), 0);
    chk("r_stop_reloads", 32'(bus.reloads), 255);

    // Pause/resume then stop in HOLD, one-shot limit 5 prescale 1
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd1);
    cyc(1);
    bus.start = 1'b0;
    cyc(2);
    chk("p_count_c3", 32'(bus.count), 1);
    cyc(1);
    bus.pause = 1'b1;
    for (int c = 5; c <= 9; c++) begin
      cyc(1);
      chk("p_hold_count", 32'(bus.count), 1);
      chk("p_hold_busy", 32'(bus.busy), 1);
      chk("p_hold_done", 32'(bus.done), 0);
    end
    chk("p_hold_state", 32'(dut.state), 32'(HOLD));
    bus.pause = 1'b0;
    cyc(1);
    chk("p_resume_c10", 32'(bus.count), 1);
    cyc(1);
    chk("p_resume_c11", 32'(bus.count), 2);
    bus.pause = 1'b1;
    cyc(1);
    chk("p_hold2_state", 32'(dut.state), 32'(HOLD));
    bus.stop = 1'b1;
    cyc(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    chk("p_stop_state", 32'(dut.state), 32'(IDLE));
    chk("p_stop_count", 32'(bus.count), 0);
    chk("p_stop_busy", 32'(bus.busy), 0);
    chk("p_stop_done", 32'(bus.done), 0);
    cyc(1);
    chk("p_stop_done2", 32'(bus.done), 0);

    // Asynchronous reset mid-run while done is high and reloads is nonzero
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0);
    cyc(1);
    bus.start = 1'b0;
    cyc(7);
    chk("x_pre_done", 32'(bus.done), 1);
    chk("x_pre_reloads", 32'(bus.reloads), 1);
    reset = 1'b0;
    #1;
    chk("x_count", 32'(bus.count), 0);
    chk("x_busy", 32'(bus.busy), 0);
    chk("x_done", 32'(bus.done), 0);
    chk("x_reloads", 32'(bus.reloads), 0);
    chk("x_state", 32'(dut.state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0);
    cyc(1);
    bus.start = 1'b0;
    chk("x_first_busy", 32'(bus.busy), 1);
    cyc(1);
    chk("x_first_count", 32'(bus.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
